// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults used by the encoder, the decoder and their benches.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_DEF = 4;
  localparam int unsigned GRAY_FN_W      = 32;

  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
    logic [GRAY_FN_W-1:0] r;
    r[GRAY_FN_W-1] = g[GRAY_FN_W-1];
    for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray encoder.
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G
);

  assign G = B ^ (B >> 1);

endmodule

// File: rtl/bin_to_gray_counter.sv
// Registered binary up/down counter with Gray-coded output for clock-domain-crossing pointers.
// Down counting is built only when BIN_TO_GRAY_COUNTER_DOWN_EN is defined.
module bin_to_gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  output logic             wrap,
  output logic             chg
);

  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] g_next;
  logic             wrap_next;
  logic             chg_next;

`ifndef BIN_TO_GRAY_COUNTER_DOWN_EN
  logic unused_dir;
  assign unused_dir = dir;
`endif

  // Next count: clr > load > en, otherwise hold.
  always_comb begin
    b_next    = B;
    wrap_next = 1'b0;
    if (clr) begin
      b_next = '0;
    end else if (load) begin
      b_next = load_val;
    end else if (en) begin
`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
      if (dir) begin
        b_next    = B - WIDTH'(1);
        wrap_next = (B == '0);
      end else begin
        b_next    = B + WIDTH'(1);
        wrap_next = (B == '1);
      end
`else
      b_next    = B + WIDTH'(1);
      wrap_next = (B == '1);
`endif
    end
  end

  bin2gray #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .B(b_next),
    .G(g_next)
  );

  assign chg_next = (g_next != G);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      B    <= '0;
      G    <= '0;
      wrap <= 1'b0;
      chg  <= 1'b0;
    end else begin
      B    <= b_next;
      G    <= g_next;
      wrap <= wrap_next;
      chg  <= chg_next;
    end
  end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed self-checking bench for bin_to_gray_counter (WIDTH = 4).
module tb_bin_to_gray_counter;
  import gray_pkg::*;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         dir;
  logic [W-1:0] B;
  logic [W-1:0] G;
  logic         wrap;
  logic         chg;

  int checks = 0;
  int errors = 0;

  bin_to_gray_counter #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .dir     (dir),
    .B       (B),
    .G       (G),
    .wrap    (wrap),
    .chg     (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] up_seq [16];
  logic [W-1:0] prev_g;
  logic [W-1:0] model_b;
  logic         model_wrap;

  initial begin
    up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b0;
    #1;
    check("rst_B", 32'(B), 32'h0);
    check("rst_G", 32'(G), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_chg", 32'(chg), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("hold_B", 32'(B), 32'h0);
    check("hold_chg", 32'(chg), 32'h0);

    // Full up sequence
    en = 1'b1;
    prev_g = G;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("up_G[%0d]", i), 32'(G), 32'(up_seq[i]));
      check($sformatf("up_wrap[%0d]", i), 32'(wrap), (i == 15) ? 32'h1 : 32'h0);
      check($sformatf("up_chg[%0d]", i), 32'(chg), 32'h1);
      check($sformatf("up_ham[%0d]", i), 32'($countones(G ^ prev_g)), 32'h1);
      prev_g = G;
    end
    check("up_end_B", 32'(B), 32'h0);

    // Load, then same load again
    en = 1'b0; load = 1'b1; load_val = 4'hA;
    tick();
    check("load_B", 32'(B), 32'hA);
    check("load_G", 32'(G), 32'hF);
    check("load_wrap", 32'(wrap), 32'h0);
    check("load_chg", 32'(chg), 32'h1);
    tick();
    check("reload_B", 32'(B), 32'hA);
    check("reload_chg", 32'(chg), 32'h0);

    // Priority: clr > load > en
    load_val = 4'h5;
    tick();
    check("prio_pre_B", 32'(B), 32'h5);
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'h9;
    tick();
    check("prio_clr_B", 32'(B), 32'h0);
    check("prio_clr_G", 32'(G), 32'h0);
    check("prio_clr_wrap", 32'(wrap), 32'h0);
    clr = 1'b0;
    tick();
    check("prio_load_B", 32'(B), 32'h9);
    check("prio_load_G", 32'(G), 32'hD);

    // Down step from zero
    load = 1'b0; en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
    check("down_B", 32'(B), 32'hF);
    check("down_G", 32'(G), 32'h8);
    check("down_wrap", 32'(wrap), 32'h1);
    tick();
    check("down2_B", 32'(B), 32'hE);
    check("down2_G", 32'(G), 32'h9);
    check("down2_wrap", 32'(wrap), 32'h0);
`else
    check("down_B", 32'(B), 32'h1);
    check("down_G", 32'(G), 32'h1);
    check("down_wrap", 32'(wrap), 32'h0);
    tick();
    check("down2_B", 32'(B), 32'h2);
    check("down2_G", 32'(G), 32'h3);
    check("down2_wrap", 32'(wrap), 32'h0);
`endif

    // Random traffic against a reference model and the Gray decoder
    model_b = B;
    for (int i = 0; i < 200; i++) begin
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = $urandom_range(0, 1) == 1;
      load_val = W'($urandom);
      model_wrap = 1'b0;
      if (clr) model_b = '0;
      else if (load) model_b = load_val;
      else if (en) begin
`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
        if (dir) begin
          model_wrap = (model_b == 4'h0);
          model_b = model_b - 4'h1;
        end else begin
          model_wrap = (model_b == 4'hF);
          model_b = model_b + 4'h1;
        end
`else
        model_wrap = (model_b == 4'hF);
        model_b = model_b + 4'h1;
`endif
      end
      tick();
      check($sformatf("rnd_B[%0d]", i), 32'(B), 32'(model_b));
      check($sformatf("rnd_rt[%0d]", i), gray2bin(32'(G)), 32'(B));
      check($sformatf("rnd_wrap[%0d]", i), 32'(wrap), 32'(model_wrap));
    end

    // Asynchronous reset mid-count
    clr = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0;
    tick();
    clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_pre_B", 32'(B), 32'h7);
    en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_B", 32'(B), 32'h0);
    check("mid_rst_G", 32'(G), 32'h0);
    check("mid_rst_wrap", 32'(wrap), 32'h0);
    check("mid_rst_chg", 32'(chg), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    tick();
    check("restart_B", 32'(B), 32'h1);
    check("restart_G", 32'(G), 32'h1);
    check("restart_chg", 32'(chg), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_gray_counter.md
# bin_to_gray_counter

Registered binary up/down counter with a Gray-coded output, the encoding-side counterpart of the team's `gray_to_binary` decoder. Each enabled step moves the count by one, so exactly one bit of the Gray output changes. Its main use is to produce pointers that are safe to pass across clock domains, for example in async FIFOs. Gray values it produces are decoded downstream by `gray_to_binary`.

## Interface
- `WIDTH`, default 4: counter width in bits. Range 2..32.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `clr`, input, 1: synchronous clear to zero.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, WIDTH: binary value to load.
- `en`, input, 1: count enable.
- `dir`, input, 1: direction, 0 = up, 1 = down. This port is always present.
- `B`, output, WIDTH: registered binary count.
- `G`, output, WIDTH: registered Gray code of `B`.
- `wrap`, output, 1: one-cycle pulse when the count wrapped around.
- `chg`, output, 1: one-cycle pulse when `G` changed on the last edge.

## Operation
- Priority on each rising edge: `clr` > `load` > `en`. With none asserted, the counter holds.
- `clr`: `B_next = 0`.
- `load`: `B_next = load_val`.
- `en`:
  - Up: `B_next = B + 1`, modulo 2^WIDTH.
  - Down: `B_next = B - 1`, modulo 2^WIDTH.
- Gray encoding: `G` is registered from `B_next ^ (B_next >> 1)`.
  - `G` is not derived combinationally from `B`.
  - `G` and `B` always update on the same edge and are always mutually consistent.
- `wrap`:
  - Set to 1 for one cycle only when an `en` step crosses from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
  - `clr` and `load` never set `wrap`, even if the new value equals the wrapped value.
- `chg`:
  - Registered as `(G_next != G)`.
  - An `en` step always sets `chg` and flips exactly one bit of `G`.
  - `clr` or `load` to the current value gives `chg = 0`.
- Arithmetic is unsigned WIDTH-bit. There is no carry-out port; `wrap` serves that purpose.

## Timing
- Reset values: `B = 0`, `G = 0`, `wrap = 0`, `chg = 0`.
- Reset takes effect immediately on the falling edge of `rst_n`, independent of `clk`.
- Reset release is sampled on the first rising edge of `clk` with `rst_n` high.
- Latency: controls sampled at edge N appear on all outputs after edge N. There is no combinational path from input to output.
- `clr`, `load` and `en` asserted together: `clr` wins; `B = 0` and `wrap = 0`.
- `load` and `en` asserted together: the loaded value is taken with no increment.
- Reset asserted mid-count: all outputs go to 0 at once, and counting restarts from 0 after release.
- `dir` is sampled only when `en` = 1.
- `wrap` and `chg` are never held high for more than one cycle unless a new qualifying event occurs on the next edge.

## Configuration
- `BIN_TO_GRAY_COUNTER_DOWN_EN`:
  - Defined: `dir` is honoured, giving up/down counting. The down-wrap sets `wrap`.
  - Undefined: `dir` is ignored, the counter counts up only, and the down-count logic is not synthesized.

## Structure
- Shared package `gray_pkg`:
  - Default width constant `GRAY_WIDTH_DEF = 4`.
  - Function `bin2gray(b)`, returning `b ^ (b >> 1)`.
  - Function `gray2bin(g)`, used by the bench and shared with `gray_to_binary`.
- Sub-module `bin2gray`: purely combinational, parameter `WIDTH`, ports `B` in and `G` out.
  - Instantiated once on `B_next`.
  - Its output feeds the `G` register.

## Test plan
- **Reset:** drive `rst_n` = 0 mid-cycle after counting to 4'h7.
  - Required: `B`, `G`, `wrap` and `chg` all read 0 before the next `clk` edge.
- **Full up sequence:** from 0, hold `en` for 16 cycles.
  - Required `G` sequence: 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - `wrap` = 1 only on the final cycle (`B` = 0).
  - `chg` = 1 on every cycle.
  - Each step has Hamming distance 1 between successive `G` values.
- **Load:** `load` = 1 with `load_val` = 4'hA.
  - Required next cycle: `B` = A, `G` = F, `wrap` = 0, `chg` = 1.
  - Repeating the same load gives `chg` = 0.
- **Priority:** from `B` = 5, assert `clr`, `load` (`load_val` = 9) and `en` in the same cycle.
  - Required: `B` = 0, `G` = 0, `wrap` = 0.
  - Then assert `load` + `en` with `load_val` = 9: `B` = 9, `G` = D.
- **Down wrap (macro defined):** from 0, `en` = 1, `dir` = 1.
  - Required: `B` = F, `G` = 8, `wrap` = 1.
  - Next step: `B` = E, `G` = 9, `wrap` = 0.
  - Without the macro, the same stimulus gives `B` = 1, `G` = 1, `wrap` = 0.
- **Round trip:** pass random load/en/clr traffic through the `gray2bin` reference on `G`.
  - Required: the decoded value equals `B` on every cycle.
